// File: rtl/debug_mem_arbiter_pkg.sv
// Shared debug package: arbiter state encodings, default starvation limit and
// the debug operation codes used by the debug transport.
package debug_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      RDATA = 2'd2
   } arb_state_e;

   localparam int unsigned STARVE_MAX_DEF = 8;

   localparam logic [1:0] DEBUGOP_NOP   = 2'd0;
   localparam logic [1:0] DEBUGOP_READ  = 2'd1;
   localparam logic [1:0] DEBUGOP_WRITE = 2'd2;

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debug_mem_arbiter.sv
// Shares one memory port between the core and the debug module. The debug
// side waits for an idle core cycle, or preempts the core once starved.
//
// state | meaning
// IDLE  | core owns memory, waiting for a debug request
// PEND  | debug request latched, waiting for an idle core cycle or starvation
// RDATA | granted read in flight, capture mem_rdata this cycle
module debug_mem_arbiter
   import debug_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              cpu_clk,
   input  logic              cpu_rstn,

   input  logic              dbg_ce,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_rvalid,
   output logic              dbg_busy,
   output logic              dbg_overrun,

   input  logic              core_ce,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,

   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  starve_tmr_q, starve_tmr_d;
   logic              req_we_q, req_we_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic              dbg_rvalid_q, dbg_rvalid_d;
   logic              dbg_overrun_q, dbg_overrun_d;
   logic              grant;

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q       <= IDLE;
         starve_tmr_q  <= '0;
         req_we_q      <= 1'b0;
         req_addr_q    <= '0;
         req_wdata_q   <= '0;
         dbg_rdata_q   <= '0;
         dbg_rvalid_q  <= 1'b0;
         dbg_overrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         starve_tmr_q  <= starve_tmr_d;
         req_we_q      <= req_we_d;
         req_addr_q    <= req_addr_d;
         req_wdata_q   <= req_wdata_d;
         dbg_rdata_q   <= dbg_rdata_d;
         dbg_rvalid_q  <= dbg_rvalid_d;
         dbg_overrun_q <= dbg_overrun_d;
      end
   end

   // The starvation timer counts down from STARVE_MAX; reaching zero forces the grant.
   always_comb begin
      state_d       = state_q;
      starve_tmr_d  = starve_tmr_q;
      req_we_d      = req_we_q;
      req_addr_d    = req_addr_q;
      req_wdata_d   = req_wdata_q;
      dbg_rdata_d   = dbg_rdata_q;
      dbg_rvalid_d  = 1'b0;
      dbg_overrun_d = dbg_overrun_q;
      grant         = 1'b0;
      mem_ce        = core_ce;
      mem_we        = core_we;
      mem_addr      = core_addr;
      mem_wdata     = core_wdata;
      core_stall    = 1'b0;

      case (state_q)
         IDLE: begin
            if (dbg_ce) begin
               req_we_d      = dbg_we;
               req_addr_d    = dbg_addr;
               req_wdata_d   = dbg_wdata;
               starve_tmr_d  = CNT_W'(STARVE_MAX);
               dbg_overrun_d = 1'b0;
               state_d       = PEND;
            end
         end
         PEND: begin
            grant = !core_ce || (starve_tmr_q == '0);
            if (grant) begin
               mem_ce     = 1'b1;
               mem_we     = req_we_q;
               mem_addr   = req_addr_q;
               mem_wdata  = req_wdata_q;
               core_stall = core_ce;
               state_d    = req_we_q ? IDLE : RDATA;
            end else begin
               starve_tmr_d = starve_tmr_q - 1'b1;
            end
         end
         RDATA: begin
            dbg_rdata_d  = mem_rdata;
            dbg_rvalid_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A strobe arriving while a request is outstanding is dropped, never latched.
      if (dbg_ce && (state_q != IDLE)) dbg_overrun_d = 1'b1;
   end

   assign dbg_busy    = (state_q != IDLE);
   assign dbg_rdata   = dbg_rdata_q;
   assign dbg_rvalid  = dbg_rvalid_q;
   assign dbg_overrun = dbg_overrun_q;
   assign core_rdata  = mem_rdata;

endmodule

// File: tb/tb_debug_mem_arbiter.sv
// Directed bench for debug_mem_arbiter with a small synchronous memory model
// and a second instance built with STARVE_MAX=0.
module tb_debug_mem_arbiter;

   logic        cpu_clk = 1'b0;
   logic        cpu_rstn;
   logic        dbg_ce, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;
   logic [31:0] dbg_rdata;
   logic        dbg_rvalid, dbg_busy, dbg_overrun;
   logic        core_ce, core_we;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        core_stall;
   logic        mem_ce, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   logic [31:0] d0_dbg_rdata, d0_core_rdata, d0_mem_addr, d0_mem_wdata;
   logic        d0_dbg_rvalid, d0_dbg_busy, d0_dbg_overrun, d0_core_stall;
   logic        d0_mem_ce, d0_mem_we;

   logic        tb_we;
   logic [7:0]  tb_waddr;
   logic [31:0] tb_wdata;
   logic [31:0] mem [0:255];

   int n_checks = 0;
   int n_errors = 0;

   always #5 cpu_clk = ~cpu_clk;

   debug_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) u_dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .dbg_busy(dbg_busy),
      .dbg_overrun(dbg_overrun),
      .core_ce(core_ce), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   debug_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0)) u_dut0 (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .dbg_ce(dbg_ce), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(d0_dbg_rdata), .dbg_rvalid(d0_dbg_rvalid), .dbg_busy(d0_dbg_busy),
      .dbg_overrun(d0_dbg_overrun),
      .core_ce(core_ce), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(d0_core_rdata), .core_stall(d0_core_stall),
      .mem_ce(d0_mem_ce), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr),
      .mem_wdata(d0_mem_wdata), .mem_rdata(32'h0)
   );

   always @(posedge cpu_clk) begin
      if (tb_we) mem[tb_waddr] <= tb_wdata;
      else if (mem_ce) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic drv;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic smp;
      @(negedge cpu_clk);
   endtask

   task automatic dbg_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      dbg_ce = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
   endtask

   task automatic dbg_idle;
      dbg_ce = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
      drv();
      tb_we = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int stalls;
      cpu_rstn = 1'b0;
      tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
      dbg_idle();
      core_ce = 1'b1; core_we = 1'b1; core_addr = 32'h5; core_wdata = 32'h77;

      // Reset: IDLE pass-through, all debug outputs low
      smp();
      chk("rst_busy", dbg_busy, 0);
      chk("rst_rvalid", dbg_rvalid, 0);
      chk("rst_rdata", dbg_rdata, 0);
      chk("rst_overrun", dbg_overrun, 0);
      chk("rst_stall", core_stall, 0);
      chk("rst_mem_ce", mem_ce, 1);
      chk("rst_mem_we", mem_we, 1);
      chk("rst_mem_addr", mem_addr, 32'h5);
      chk("rst_mem_wdata", mem_wdata, 32'h77);
      drv();
      core_ce = 1'b0; core_we = 1'b0; core_addr = 32'h40; core_wdata = '0;
      preload(8'h10, 32'hDEADBEEF);
      preload(8'h20, 32'h0);
      preload(8'h30, 32'hCAFE0000);
      cpu_rstn = 1'b1;
      drv(); drv();

      // Idle-core debug read: minimum latency
      dbg_req(1'b0, 32'h10, 32'h0);                     // cycle 0
      smp(); chk("rd_c0_busy", dbg_busy, 0); chk("rd_c0_mem_ce", mem_ce, 0);
      drv(); dbg_idle();                                 // cycle 1
      smp();
      chk("rd_c1_mem_ce", mem_ce, 1); chk("rd_c1_mem_we", mem_we, 0);
      chk("rd_c1_mem_addr", mem_addr, 32'h10); chk("rd_c1_busy", dbg_busy, 1);
      drv(); smp();                                      // cycle 2
      chk("rd_c2_rvalid", dbg_rvalid, 0); chk("rd_c2_core_rdata", core_rdata, 32'hDEADBEEF);
      chk("rd_c2_busy", dbg_busy, 1);
      drv(); smp();                                      // cycle 3
      chk("rd_c3_rvalid", dbg_rvalid, 1); chk("rd_c3_rdata", dbg_rdata, 32'hDEADBEEF);
      chk("rd_c3_busy", dbg_busy, 0);
      drv(); smp();                                      // cycle 4
      chk("rd_c4_rvalid", dbg_rvalid, 0); chk("rd_c4_rdata_hold", dbg_rdata, 32'hDEADBEEF);

      // Starved write: core busy throughout, grant on the ninth PEND cycle
      drv();
      core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h40;
      dbg_req(1'b1, 32'h20, 32'hA5A5A5A5);              // cycle 0
      stalls = 0;
      smp(); stalls += int'(core_stall);
      drv(); dbg_idle();                                 // cycle 1
      smp();
      chk("z0_mem_ce", d0_mem_ce, 1); chk("z0_mem_addr", d0_mem_addr, 32'h20);
      chk("z0_mem_we", d0_mem_we, 1); chk("z0_stall", d0_core_stall, 1);
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) begin drv(); smp(); end
         stalls += int'(core_stall);
         chk($sformatf("st_c%0d_mem_addr", c), mem_addr, 32'h40);
         chk($sformatf("st_c%0d_busy", c), dbg_busy, 1);
      end
      drv(); smp();                                      // cycle 9
      stalls += int'(core_stall);
      chk("st_c9_stall", core_stall, 1); chk("st_c9_mem_addr", mem_addr, 32'h20);
      chk("st_c9_mem_we", mem_we, 1); chk("st_c9_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      drv();                                             // cycle 10
      core_ce = 1'b0;
      dbg_req(1'b0, 32'h20, 32'h0);
      smp();
      chk("st_stall_total", stalls, 1); chk("st_c10_stall", core_stall, 0);
      chk("st_c10_busy", dbg_busy, 0); chk("st_mem20", mem[8'h20], 32'hA5A5A5A5);
      chk("st_rdata_kept", dbg_rdata, 32'hDEADBEEF);
      drv(); dbg_idle(); smp();                          // cycle 11
      chk("b2b_grant_ce", mem_ce, 1); chk("b2b_grant_addr", mem_addr, 32'h20);
      drv(); drv(); smp();                               // cycle 13
      chk("b2b_rvalid", dbg_rvalid, 1); chk("b2b_rdata", dbg_rdata, 32'hA5A5A5A5);

      // Core busy for 3 cycles, then idle: grant in first idle cycle, no stall
      drv();
      core_ce = 1'b1; core_addr = 32'h44;
      dbg_req(1'b0, 32'h10, 32'h0);
      stalls = 0;
      smp(); stalls += int'(core_stall);
      drv(); dbg_idle(); smp(); stalls += int'(core_stall);
      chk("ci_c1_mem_addr", mem_addr, 32'h44);
      drv(); smp(); stalls += int'(core_stall);
      drv(); core_ce = 1'b0; smp(); stalls += int'(core_stall);
      chk("ci_c3_mem_ce", mem_ce, 1); chk("ci_c3_mem_addr", mem_addr, 32'h10);
      drv(); smp(); stalls += int'(core_stall);
      drv(); smp();
      chk("ci_stalls", stalls, 0); chk("ci_rvalid", dbg_rvalid, 1);
      chk("ci_rdata", dbg_rdata, 32'hDEADBEEF);

      // Overrun: second strobe while PEND is dropped
      drv();
      core_ce = 1'b1; core_addr = 32'h40;
      dbg_req(1'b0, 32'h20, 32'h0);                     // cycle 0
      drv(); dbg_idle();                                 // cycle 1
      drv(); dbg_req(1'b1, 32'h30, 32'h1234);           // cycle 2
      drv(); dbg_idle(); smp();                          // cycle 3
      chk("ov_flag", dbg_overrun, 1); chk("ov_busy", dbg_busy, 1);
      for (int c = 4; c <= 9; c++) drv();                // cycle 9
      smp();
      chk("ov_grant_addr", mem_addr, 32'h20); chk("ov_grant_we", mem_we, 0);
      chk("ov_grant_stall", core_stall, 1);
      drv(); core_ce = 1'b0;                             // cycle 10
      drv(); smp();                                      // cycle 11
      chk("ov_rvalid", dbg_rvalid, 1); chk("ov_rdata", dbg_rdata, 32'hA5A5A5A5);
      drv(); dbg_req(1'b1, 32'h30, 32'h11112222); smp(); // cycle 12
      chk("ov_still_set", dbg_overrun, 1); chk("ov_mem30_untouched", mem[8'h30], 32'hCAFE0000);
      drv(); dbg_idle(); smp();                          // cycle 13
      chk("ov_cleared", dbg_overrun, 0); chk("ov_wr_addr", mem_addr, 32'h30);
      drv(); smp();
      chk("ov_mem30", mem[8'h30], 32'h11112222);

      // Reset during RDATA abandons the read
      drv(); dbg_req(1'b0, 32'h30, 32'h0);              // cycle 0
      drv(); dbg_idle();                                 // cycle 1
      drv();                                             // cycle 2, RDATA
      cpu_rstn = 1'b0;
      #1;
      chk("mr_busy", dbg_busy, 0); chk("mr_rvalid", dbg_rvalid, 0);
      chk("mr_rdata", dbg_rdata, 0); chk("mr_overrun", dbg_overrun, 0);
      chk("mr_stall", core_stall, 0);
      drv(); cpu_rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         smp(); chk($sformatf("mr_no_rvalid%0d", c), dbg_rvalid, 0);
         drv();
      end
      dbg_req(1'b0, 32'h10, 32'h0);                     // cycle 0
      drv(); dbg_idle(); smp();                          // cycle 1
      chk("mr2_mem_ce", mem_ce, 1); chk("mr2_mem_addr", mem_addr, 32'h10);
      drv(); drv(); smp();                               // cycle 3
      chk("mr2_rvalid", dbg_rvalid, 1); chk("mr2_rdata", dbg_rdata, 32'hDEADBEEF);
      chk("mr2_busy", dbg_busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/debug_mem_arbiter.md
DEBUG_MEM_ARBITER -- requirements
Module: debug_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: memory address width.
REQ-002 SHALL have parameter DATA_W, default 32: memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 8: the number of core-busy cycles a pending debug request waits before it preempts the core.
REQ-004 SHALL have ports: cpu_clk in 1, clock; cpu_rstn in 1, reset, asynchronous, active-low.
REQ-005 SHALL have debug-side ports: dbg_ce in 1, one-cycle request strobe; dbg_we in 1, write qualifier; dbg_addr in ADDR_W; dbg_wdata in DATA_W.
REQ-006 SHALL have debug-side ports: dbg_rdata out DATA_W, captured read data; dbg_rvalid out 1, read-done pulse; dbg_busy out 1, request pending; dbg_overrun out 1, sticky dropped-request flag.
REQ-007 SHALL have core-side ports: core_ce in 1; core_we in 1; core_addr in ADDR_W; core_wdata in DATA_W; core_rdata out DATA_W; core_stall out 1.
REQ-008 SHALL have memory-side ports: mem_ce out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid one cycle after a read mem_ce.

Function
REQ-009 SHALL implement an FSM with states IDLE, PEND, RDATA.
REQ-010 IDLE: mem_* SHALL equal core_*; core_stall=0; on dbg_ce=1, latch dbg_we/addr/wdata, clear starve_cnt, enter PEND.
REQ-011 PEND, grant condition: a grant SHALL occur in the cycle in which core_ce=0 or starve_cnt==STARVE_MAX.
REQ-012 PEND, grant cycle: mem_ce=1, mem_we/addr/wdata SHALL come from the latched request; core_stall=core_ce.
REQ-013 PEND, grant transitions: a granted write SHALL go to IDLE; a granted read SHALL go to RDATA.
REQ-014 PEND, non-grant cycle: mem_* SHALL equal core_*; core_stall=0; starve_cnt SHALL increment and saturate at STARVE_MAX.
REQ-015 RDATA: mem_* SHALL equal core_*; the core SHALL use memory freely; mem_rdata SHALL be registered into dbg_rdata; dbg_rvalid=1 in the following cycle only; next state IDLE.
REQ-016 dbg_busy SHALL be 1 exactly while state is PEND or RDATA (registered state decode).
REQ-017 core_rdata SHALL be a combinational pass-through of mem_rdata; the core SHALL hold its request stable while core_stall=1.
REQ-018 dbg_rdata SHALL hold its value until the next debug read completes; debug writes SHALL NOT change it.
REQ-019 Minimum latency: dbg_ce in cycle 0, grant in cycle 1, capture in cycle 2, dbg_rvalid=1 in cycle 3.
REQ-020 dbg_ce while dbg_busy=1 SHALL be dropped and SHALL set dbg_overrun; the latched request SHALL be unaffected.
REQ-021 dbg_overrun SHALL clear on the next accepted dbg_ce.
REQ-022 starve_cnt SHALL be wide enough to hold STARVE_MAX; STARVE_MAX=0 SHALL grant in the first PEND cycle unconditionally.
REQ-023 Two consecutive requests: dbg_ce in the cycle after a write grant SHALL be accepted (state IDLE).

Reset
REQ-024 Asserting cpu_rstn low SHALL force state IDLE, starve_cnt=0, dbg_rdata=0, dbg_rvalid=0, dbg_overrun=0, dbg_busy=0, and the latched request to 0.
REQ-025 mem_* and core_stall SHALL follow IDLE rules during reset.
REQ-026 Reset mid-PEND or mid-RDATA SHALL abandon the request; no dbg_rvalid SHALL be issued afterwards.

Structure
REQ-027 State encodings and default STARVE_MAX SHALL live in the shared debug package alongside the DEBUGOP constants.
REQ-028 The block SHALL be a single flat module; no sub-module is required.
REQ-029 The block SHALL be instantiated once per memory port (imem, dmem).

Verification
REQ-030 Idle core, dbg read addr 0x10 with mem[0x10]=0xDEADBEEF -> mem_ce at cycle 1; dbg_rdata=0xDEADBEEF and dbg_rvalid=1 at cycle 3; dbg_busy=0 at cycle 3.
REQ-031 Core_ce held 1 continuously, dbg write 0xA5A5A5A5 to 0x20, STARVE_MAX=8 -> grant after exactly 8 PEND cycles; core_stall=1 for one cycle only; mem[0x20]=0xA5A5A5A5.
REQ-032 Core_ce=1 for 3 cycles then 0 -> debug granted in the first core-idle cycle; core_stall never asserted.
REQ-033 Second dbg_ce while PEND -> dbg_overrun=1; first request completes unchanged; next accepted dbg_ce clears dbg_overrun.
REQ-034 cpu_rstn pulsed low in RDATA -> all outputs 0; no dbg_rvalid afterwards; the next request behaves as in REQ-030.
